// File: rtl/outputport.sv
// Bundled-data 4-phase output port: hands one synchronous word at a time to an
// asynchronous receiver, counting completed transfers and flagging early acks.
module outputport #(
    parameter int WIDTH = 8,
    parameter int SETUP = 2
) (
    input  logic             clk_outputport,
    input  logic             reset,
    input  logic             valid_in,
    input  logic [WIDTH-1:0] data_in,
    output logic             ready,
    output logic             req,
    input  logic             ack,
    output logic [WIDTH-1:0] data_out,
    output logic             busy,
    output logic [15:0]      tx_count,
    output logic             proto_err
);

    localparam int          SYNC_STAGES = 2;
    localparam logic [3:0]  SETUP_INIT  = 4'(SETUP);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_REQ_HI,
        ST_REQ_LO
    } state_t;

    state_t                 state_reg;
    logic [3:0]             setup_cnt_reg;
    logic                   req_reg;
    logic [WIDTH-1:0]       data_out_reg;
    logic [15:0]            tx_count_reg;
    logic                   proto_err_reg;
    logic [SYNC_STAGES-1:0] ack_sync_reg;
    logic                   ack_s;

    // Raw ack is only ever seen by the first synchroniser stage.
    generate
        for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_ack_sync
            logic stage_in;
            if (gi == 0) begin : g_first
                assign stage_in = ack;
            end else begin : g_chain
                assign stage_in = ack_sync_reg[gi-1];
            end
            always_ff @(posedge clk_outputport or posedge reset) begin
                if (reset) begin
                    ack_sync_reg[gi] <= 1'b0;
                end else begin
                    ack_sync_reg[gi] <= stage_in;
                end
            end
        end
    endgenerate

    assign ack_s = ack_sync_reg[SYNC_STAGES-1];

    always_ff @(posedge clk_outputport or posedge reset) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            setup_cnt_reg <= 4'd0;
            req_reg       <= 1'b0;
            data_out_reg  <= '0;
            tx_count_reg  <= 16'd0;
            proto_err_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (ack_s) begin
                        proto_err_reg <= 1'b1;
                    end
                    if (valid_in) begin
                        data_out_reg  <= data_in;
                        setup_cnt_reg <= SETUP_INIT;
                        state_reg     <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    // An early ack is flagged but never alters the sequence.
                    if (ack_s) begin
                        proto_err_reg <= 1'b1;
                    end
                    setup_cnt_reg <= setup_cnt_reg - 4'd1;
                    if (setup_cnt_reg <= 4'd1) begin
                        req_reg   <= 1'b1;
                        state_reg <= ST_REQ_HI;
                    end
                end
                ST_REQ_HI: begin
                    if (ack_s) begin
                        req_reg   <= 1'b0;
                        state_reg <= ST_REQ_LO;
                    end
                end
                ST_REQ_LO: begin
                    if (!ack_s) begin
                        tx_count_reg <= tx_count_reg + 16'd1;
                        state_reg    <= ST_IDLE;
                    end
                end
                default: begin
                    req_reg   <= 1'b0;
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign ready     = (state_reg == ST_IDLE);
    assign busy      = (state_reg != ST_IDLE);
    assign req       = req_reg;
    assign data_out  = data_out_reg;
    assign tx_count  = tx_count_reg;
    assign proto_err = proto_err_reg;

endmodule
